// File: rtl/muldiv_ctrl_if.sv
// Command, unit-control and HI/LO signals between the CPU control unit, muldiv_ctrl and the shared mult/div units.
// slave is the sequencer view; master is the mirror seen by the control unit and the arithmetic units.
interface muldiv_ctrl_if;
  logic        op_valid;
  logic        op_sel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        op_ready;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        timeout_err;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        mult_rst;
  logic        div_rst;
  logic        mult_start;
  logic        div_start;
  logic        mult_done;
  logic        div_done;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport slave (
    input  op_valid, op_sel, rs_val, rt_val,
    input  mult_done, div_done, mult_hi, mult_lo, div_hi, div_lo,
    input  hilo_we, hilo_sel, hilo_wdata,
    output op_ready, busy, done, div_zero, timeout_err,
    output unit_a, unit_b, mult_rst, div_rst, mult_start, div_start,
    output hi_out, lo_out
  );

  modport master (
    output op_valid, op_sel, rs_val, rt_val,
    output mult_done, div_done, mult_hi, mult_lo, div_hi, div_lo,
    output hilo_we, hilo_sel, hilo_wdata,
    input  op_ready, busy, done, div_zero, timeout_err,
    input  unit_a, unit_b, mult_rst, div_rst, mult_start, div_start,
    input  hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// MULT/DIV sequencer owning HI/LO: accept -> clear unit -> start -> wait (bounded by TIMEOUT) -> commit; one op in flight.
// Latency: unit latency + 3 cycles to the done pulse; backpressure: op_ready only in IDLE, HI/LO writes dropped while busy.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_ABORT  = 3'd5;

  localparam logic [6:0] TMO = 7'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic        sel_q, sel_d;
  logic [31:0] unit_a_q, unit_a_d;
  logic [31:0] unit_b_q, unit_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        mult_rst_q, mult_rst_d;
  logic        div_rst_q, div_rst_d;
  logic        mult_start_q, mult_start_d;
  logic        div_start_q, div_start_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic        timeout_err_q, timeout_err_d;

  // The unselected unit's done and results are never looked at.
  logic        unit_done;
  logic [31:0] unit_hi;
  logic [31:0] unit_lo;

  assign unit_done = sel_q ? bus.div_done : bus.mult_done;
  assign unit_hi   = sel_q ? bus.div_hi   : bus.mult_hi;
  assign unit_lo   = sel_q ? bus.div_lo   : bus.mult_lo;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    unit_a_d      = unit_a_q;
    unit_b_d      = unit_b_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    cnt_d         = cnt_q;
    mult_rst_d    = 1'b0;
    div_rst_d     = 1'b0;
    mult_start_d  = 1'b0;
    div_start_d   = 1'b0;
    done_d        = 1'b0;
    div_zero_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.hilo_we) begin
          if (bus.hilo_sel) hi_d = bus.hilo_wdata;
          else              lo_d = bus.hilo_wdata;
        end
        if (bus.op_valid) begin
          unit_a_d = bus.rs_val;
          unit_b_d = bus.rt_val;
          sel_d    = bus.op_sel;
          if (bus.op_sel && (bus.rt_val == 32'd0)) begin
            div_zero_d = 1'b1;
          end else begin
            state_d    = S_CLR;
            mult_rst_d = ~bus.op_sel;
            div_rst_d  = bus.op_sel;
          end
        end
      end
      S_CLR: begin
        state_d      = S_START;
        mult_start_d = ~sel_q;
        div_start_d  = sel_q;
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = 7'd0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 7'd1;
        if (unit_done) begin
          hi_d    = unit_hi;
          lo_d    = unit_lo;
          done_d  = 1'b1;
          state_d = S_COMMIT;
        end else if (cnt_d == TMO) begin
          // Reset the stuck unit during ABORT so its state is clean for the next op.
          mult_rst_d    = ~sel_q;
          div_rst_d     = sel_q;
          timeout_err_d = 1'b1;
          state_d       = S_ABORT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      sel_q         <= 1'b0;
      unit_a_q      <= 32'd0;
      unit_b_q      <= 32'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      cnt_q         <= 7'd0;
      mult_rst_q    <= 1'b0;
      div_rst_q     <= 1'b0;
      mult_start_q  <= 1'b0;
      div_start_q   <= 1'b0;
      done_q        <= 1'b0;
      div_zero_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      unit_a_q      <= unit_a_d;
      unit_b_q      <= unit_b_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      cnt_q         <= cnt_d;
      mult_rst_q    <= mult_rst_d;
      div_rst_q     <= div_rst_d;
      mult_start_q  <= mult_start_d;
      div_start_q   <= div_start_d;
      done_q        <= done_d;
      div_zero_q    <= div_zero_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.op_ready    = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_zero    = div_zero_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.unit_a      = unit_a_q;
  assign bus.unit_b      = unit_b_q;
  assign bus.mult_rst    = mult_rst_q;
  assign bus.div_rst     = div_rst_q;
  assign bus.mult_start  = mult_start_q;
  assign bus.div_start   = div_start_q;
  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed ops with behavioural mult/div unit models; pulses are scored against a queue.
module tb_muldiv_ctrl;
  logic clk;
  logic reset;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.TIMEOUT(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_DZ   = 2'd2;
  localparam logic [1:0] K_TO   = 2'd3;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mult_en = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Multiplier model: done 34 cycles after start, sticky until mult_rst.
  int m_cnt;
  bit m_act;
  always @(negedge clk) begin
    logic signed [63:0] prod;
    if (!reset) begin
      m_act = 0; m_cnt = 0;
      bus.mult_done = 1'b0; bus.mult_hi = 32'd0; bus.mult_lo = 32'd0;
    end else if (bus.mult_rst) begin
      m_act = 0; bus.mult_done = 1'b0;
    end else if (bus.mult_start) begin
      m_act = 1; m_cnt = 0;
    end else if (m_act && !bus.mult_done) begin
      m_cnt++;
      if (m_cnt == 34 && mult_en) begin
        prod = $signed(bus.unit_a) * $signed(bus.unit_b);
        bus.mult_hi = prod[63:32];
        bus.mult_lo = prod[31:0];
        bus.mult_done = 1'b1;
      end
    end
  end

  // Divider model: done 10 cycles after start.
  int d_cnt;
  bit d_act;
  always @(negedge clk) begin
    if (!reset) begin
      d_act = 0; d_cnt = 0;
      bus.div_done = 1'b0; bus.div_hi = 32'd0; bus.div_lo = 32'd0;
    end else if (bus.div_rst) begin
      d_act = 0; bus.div_done = 1'b0;
    end else if (bus.div_start) begin
      d_act = 1; d_cnt = 0;
    end else if (d_act && !bus.div_done) begin
      d_cnt++;
      if (d_cnt == 10 && bus.unit_b != 32'd0) begin
        bus.div_lo = $signed(bus.unit_a) / $signed(bus.unit_b);
        bus.div_hi = $signed(bus.unit_a) % $signed(bus.unit_b);
        bus.div_done = 1'b1;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [1:0] k;
    exp_t e;
    if (reset === 1'b1 && (bus.done === 1'b1 || bus.div_zero === 1'b1 || bus.timeout_err === 1'b1)) begin
      k = bus.done ? K_DONE : (bus.div_zero ? K_DZ : K_TO);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'(k), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 64'(k), 64'(e.kind));
        chk("pulse_hi", 64'(bus.hi_out), 64'(e.hi));
        chk("pulse_lo", 64'(bus.lo_out), 64'(e.lo));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sel, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (bus.op_ready !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) chk("ready_wait_expired", 64'd0, 64'd1);
    bus.op_valid = 1'b1;
    bus.op_sel   = sel;
    bus.rs_val   = a;
    bus.rt_val   = b;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic mt(input logic sel, input logic [31:0] data);
    bus.hilo_we    = 1'b1;
    bus.hilo_sel   = sel;
    bus.hilo_wdata = data;
    tick();
    bus.hilo_we    = 1'b0;
  endtask

  task automatic wait_end(input int lim, output int c, output logic m_seen, output logic d_seen);
    c = 0; m_seen = 1'b0; d_seen = 1'b0;
    while (!(bus.done === 1'b1 || bus.timeout_err === 1'b1) && c < lim) begin
      tick();
      c++;
      m_seen = m_seen | bus.mult_rst | bus.mult_start;
      d_seen = d_seen | bus.div_start;
    end
  endtask

  initial begin
    int   c;
    logic ms, ds;
    logic [6:0] strobes;

    reset = 1'b0;
    bus.op_valid = 1'b0; bus.op_sel = 1'b0; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    bus.hilo_we = 1'b0; bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    strobes = {bus.mult_rst, bus.div_rst, bus.mult_start, bus.div_start, bus.done, bus.div_zero, bus.timeout_err};
    chk("rst_hi", 64'(bus.hi_out), 64'd0);
    chk("rst_lo", 64'(bus.lo_out), 64'd0);
    chk("rst_unit_ab", {bus.unit_a, bus.unit_b}, 64'd0);
    chk("rst_ready_busy", 64'({bus.op_ready, bus.busy}), 64'b10);
    chk("rst_strobes", 64'(strobes), 64'd0);
    reset = 1'b1;
    tick();

    // MULT 7 * -3
    sb.push_back('{K_DONE, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("mult_t1_rst", 64'({bus.mult_rst, bus.div_rst, bus.mult_start, bus.busy}), 64'b1001);
    chk("mult_t1_operands", {bus.unit_a, bus.unit_b}, {32'd7, 32'hFFFF_FFFD});
    tick();
    chk("mult_t2_start", 64'({bus.mult_rst, bus.mult_start, bus.div_start}), 64'b010);
    wait_end(60, c, ms, ds);
    chk("mult_latency", 64'(c), 64'd35);
    chk("mult_commit_busy", 64'(bus.busy), 64'd1);
    tick();
    chk("mult_ready_after", 64'(bus.op_ready), 64'd1);

    // Back-to-back MULT: full latency again
    sb.push_back('{K_DONE, 32'd0, 32'd30});
    issue(1'b0, 32'd5, 32'd6);
    tick();
    wait_end(60, c, ms, ds);
    chk("mult2_latency", 64'(c), 64'd35);
    tick();

    // DIV 100 / 7
    sb.push_back('{K_DONE, 32'd2, 32'd14});
    issue(1'b1, 32'd100, 32'd7);
    chk("div_t1_rst", 64'({bus.div_rst, bus.mult_rst}), 64'b10);
    tick();
    chk("div_t2_start", 64'({bus.div_start, bus.mult_start}), 64'b10);
    wait_end(60, c, ms, ds);
    chk("div_latency", 64'(c), 64'd11);
    chk("div_no_mult_strobes", 64'(ms), 64'd0);
    tick();

    // MTHI / MTLO preload
    mt(1'b1, 32'h0000_AAAA);
    chk("mthi", 64'(bus.hi_out), 64'h0000_AAAA);
    mt(1'b0, 32'h0000_5555);
    chk("mtlo", {bus.hi_out, bus.lo_out}, {32'h0000_AAAA, 32'h0000_5555});

    // DIV by zero
    sb.push_back('{K_DZ, 32'h0000_AAAA, 32'h0000_5555});
    issue(1'b1, 32'd123, 32'd0);
    chk("dz_pulse_ready", 64'({bus.div_zero, bus.op_ready, bus.div_rst}), 64'b110);
    tick();
    chk("dz_one_cycle", 64'(bus.div_zero), 64'd0);
    ds = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ds = ds | bus.div_start | bus.div_rst | ~bus.op_ready;
      tick();
    end
    chk("dz_no_unit_activity", 64'(ds), 64'd0);

    // Timeout with a busy-time MTHI that must be dropped
    mult_en = 1'b0;
    sb.push_back('{K_TO, 32'h0000_AAAA, 32'h0000_5555});
    issue(1'b0, 32'd9, 32'd9);
    tick();
    c = 0;
    while (bus.timeout_err !== 1'b1 && c < 60) begin
      tick();
      c++;
      if (c == 5) begin
        bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wdata = 32'h0000_1234;
      end else begin
        bus.hilo_we = 1'b0;
      end
    end
    bus.hilo_we = 1'b0;
    chk("timeout_latency", 64'(c), 64'd41);
    chk("timeout_unit_rst", 64'({bus.mult_rst, bus.done}), 64'b10);
    chk("busy_write_dropped", 64'(bus.hi_out), 64'h0000_AAAA);
    tick();
    chk("timeout_ready_after", 64'({bus.op_ready, bus.timeout_err}), 64'b10);
    mult_en = 1'b1;

    // MTHI in IDLE
    mt(1'b1, 32'h0000_1234);
    chk("idle_write", {bus.hi_out, bus.lo_out}, {32'h0000_1234, 32'h0000_5555});

    // Reset mid-WAIT, then MULT 2 * 3
    issue(1'b0, 32'd11, 32'd13);
    tick();
    repeat (10) tick();
    #1 reset = 1'b0;
    #1;
    strobes = {bus.mult_rst, bus.div_rst, bus.mult_start, bus.div_start, bus.done, bus.div_zero, bus.timeout_err};
    chk("midrst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    chk("midrst_unit_ab", {bus.unit_a, bus.unit_b}, 64'd0);
    chk("midrst_ready_busy", 64'({bus.op_ready, bus.busy}), 64'b10);
    chk("midrst_strobes", 64'(strobes), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    sb.push_back('{K_DONE, 32'd0, 32'd6});
    issue(1'b0, 32'd2, 32'd3);
    tick();
    wait_end(60, c, ms, ds);
    chk("post_rst_latency", 64'(c), 64'd35);
    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
